fib_bcd_conv: RTL and testbench
===============================

# fib_bcd_conv

Downstream stage of the `fib` generator. Converts one 128-bit unsigned binary value (`fib_out`) into packed BCD decimal digits so the value can be displayed or printed digit by digit. Uses an iterative shift-and-add-3 (double-dabble) datapath, processing one bit per clock. Valid/ready handshakes are provided on both the input and the output side.

## Interface
- `WIDTH`, default 128: binary input width.
- `DIGITS`, default 39: number of BCD digits. Must satisfy DIGITS ≥ ceil(WIDTH·log10 2); 39 covers 128 bits.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `bin_in` in WIDTH: unsigned binary value to convert; normally driven by `fib_out`.
- `in_valid` in 1: `bin_in` is valid this cycle.
- `in_ready` out 1: block accepts a new value this cycle.
- `bcd_out` out 4·DIGITS: packed BCD; digit 0 (least significant) in [3:0].
- `ndigits` out 6: count of significant decimal digits in `bcd_out`, range 1..DIGITS; a value of 0 reports 1.
- `out_valid` out 1: `bcd_out` and `ndigits` hold a completed result.
- `out_ready` in 1: consumer takes the result this cycle.

## Operation
- States: IDLE, CONV, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid && in_ready`: load the shift register with `bin_in`, clear the BCD accumulator, set iteration counter to 0, go to CONV.
- **CONV** (one iteration per edge)
  - For every digit ≥ 5, add 3.
  - Then shift {BCD, bin} left by 1; the bin MSB enters BCD bit 0.
  - Counter increments each iteration.
  - After the WIDTH-th iteration, go to DONE.
- **DONE**
  - `out_valid` = 1.
  - `bcd_out` and `ndigits` are held stable until `out_valid && out_ready`, then go to IDLE.
- `ndigits`: combinational from the registered BCD accumulator, computed as 1 + index of the highest nonzero digit, or 1 if every digit is zero.
- `in_ready` is asserted only in IDLE. Input is ignored in CONV and DONE, and is never sampled outside a handshake.
- `out_ready` is ignored outside DONE.
- Width rules:
  - Add-3 is applied only to digits 0..DIGITS-1. Each digit is 4 bits and never exceeds 9 after adjustment.
  - The iteration counter is $clog2(WIDTH+1) bits; it does not wrap within a conversion.
- Reset, including during CONV or DONE:
  - Next state is IDLE; the in-flight result is discarded.
  - `out_valid` = 0, `bcd_out` = 0, `ndigits` = 1, `in_ready` = 1 after the reset edge.

## Timing
- Accept edge E (the `in_valid && in_ready` edge): `in_ready` drops to 0 in the cycle after E.
- Iterations occur on edges E+1 .. E+WIDTH.
- `out_valid` is high in the cycle following edge E+WIDTH. Latency is WIDTH cycles after the accept edge, i.e. 128 by default.
- Output-handshake edge F: `out_valid` goes to 0 and `in_ready` goes to 1 in the cycle after F.
- Minimum spacing between accepts is WIDTH+2 cycles when `out_ready` is tied high. There is no overlap of conversions.
- Holding `out_ready` low stalls indefinitely. Outputs stay bit-stable and `in_ready` stays 0 for the whole stall.
- `in_valid` asserted together with reset: the reset wins and no accept occurs on that edge.

## Structure
- Shared package `fib_pkg` contains:
  - `FIB_WIDTH` = 128 and `FIB_BCD_DIGITS` = 39. `fib` and this block use these as parameter defaults.
  - `conv_state_t` enum {IDLE, CONV, DONE}.
- Sub-module `bcd_digit_adj`: combinational 4-bit in → 4-bit out, returns d+3 if d ≥ 5, else d. Instantiated DIGITS times via generate.
- Everything else lives in `fib_bcd_conv`: FSM, counter, shift register, and `ndigits` priority encoder.

## Test plan
- **Zero:** `bin_in`=0 accepted at edge E → `out_valid` in the cycle after E+128, `bcd_out`=0, `ndigits`=1.
- **Small value:** `bin_in`=12345 → `bcd_out[19:0]`=0x12345, upper digits 0, `ndigits`=5.
- **Maximum:** `bin_in`=2^128−1 → digits read 340282366920938463463374607431768211455, `ndigits`=39.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid` → `bcd_out` stable, `in_ready`=0, and a pulsed `in_valid` is ignored. Then `out_ready`=1 → `in_ready`=1 in the next cycle.
- **Reset mid-conversion:** assert `rst` for one cycle at iteration 50 → next cycle `out_valid`=0, `in_ready`=1, `bcd_out`=0. A following conversion of 55 yields 0x55 with `ndigits`=2.
- **Chained with `fib`:** sample F(100)=354224848179261915075 → `ndigits`=21 and digits match. Also check F(10)=55.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared definitions for the fib generator and its BCD conversion stage.
package fib_pkg;

    localparam int unsigned FIB_WIDTH      = 128;
    localparam int unsigned FIB_BCD_DIGITS = 39;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    always_comb begin
        o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;
    end

endmodule

// File: rtl/fib_bcd_conv.sv
// Iterative binary-to-BCD converter, one bit per clock, with valid/ready on both sides.
module fib_bcd_conv
    import fib_pkg::*;
#(
    parameter int unsigned WIDTH  = FIB_WIDTH,
    parameter int unsigned DIGITS = FIB_BCD_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      bin_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [5:0]            ndigits,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    conv_state_t         r_state;
    logic [WIDTH-1:0]    r_bin;
    logic [4*DIGITS-1:0] r_bcd;
    logic [CW-1:0]       r_cnt;
    logic [4*DIGITS-1:0] w_adj;
    logic [5:0]          w_nd;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_bcd[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_bin   <= bin_in;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_state <= CONV;
                    end
                end
                CONV: begin
                    // Adjusted digits shift up one bit; the binary MSB enters BCD bit 0.
                    r_bcd <= {w_adj[4*DIGITS-2:0], r_bin[WIDTH-1]};
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Highest nonzero digit wins; an all-zero value still reports one digit.
    always_comb begin
        w_nd = 6'd1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] != 4'd0) begin
                w_nd = 6'(i + 1);
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign bcd_out   = r_bcd;
    assign ndigits   = w_nd;

endmodule

// File: tb/tb_fib_bcd_conv.sv
// Scoreboard bench for fib_bcd_conv: directed values with hand-computed BCD results.
module tb_fib_bcd_conv;
    import fib_pkg::*;

    localparam int unsigned W = 128;
    localparam int unsigned D = 39;

    typedef struct packed {
        logic [4*D-1:0] bcd;
        logic [5:0]     nd;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   bin_in;
    logic           in_valid;
    logic           in_ready;
    logic [4*D-1:0] bcd_out;
    logic [5:0]     ndigits;
    logic           out_valid;
    logic           out_ready;

    exp_t        q[$];
    int unsigned tests = 0;
    int unsigned fails = 0;

    fib_bcd_conv #(.WIDTH(W), .DIGITS(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .bin_in    (bin_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_out   (bcd_out),
        .ndigits   (ndigits),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake must match the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready && !rst) begin
                if (q.size() == 0) begin
                    check("unexpected_output", 160'(bcd_out), 160'(0));
                end else begin
                    e = q.pop_front();
                    check("bcd_out", 160'(bcd_out), 160'(e.bcd));
                    check("ndigits", 160'(ndigits), 160'(e.nd));
                end
            end
        end
    end

    task automatic convert(input logic [W-1:0] v, input logic [4*D-1:0] eb,
                           input logic [5:0] en, input int unsigned stall);
        exp_t           e;
        int unsigned    n;
        logic [4*D-1:0] snap;
        e.bcd = eb;
        e.nd  = en;
        check("in_ready_idle", 160'(in_ready), 160'(1));
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        bin_in    = v;
        q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        bin_in   = '0;
        check("in_ready_drop", 160'(in_ready), 160'(0));
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 160'(n), 160'(128));
        if (stall != 0) begin
            snap = bcd_out;
            for (int i = 0; i < int'(stall); i++) begin
                @(posedge clk); #1;
                in_valid = (i == 3);
                bin_in   = (i == 3) ? W'(999) : '0;
                check("stall_bcd", 160'(bcd_out), 160'(snap));
                check("stall_in_ready", 160'(in_ready), 160'(0));
                check("stall_out_valid", 160'(out_valid), 160'(1));
            end
            in_valid  = 1'b0;
            bin_in    = '0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("out_valid_drop", 160'(out_valid), 160'(0));
        check("in_ready_back", 160'(in_ready), 160'(1));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        bin_in    = W'(77);
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_in_ready", 160'(in_ready), 160'(1));
        check("rst_out_valid", 160'(out_valid), 160'(0));
        check("rst_bcd", 160'(bcd_out), 160'(0));
        check("rst_ndigits", 160'(ndigits), 160'(1));
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("no_accept_in_reset", 160'(in_ready), 160'(1));

        convert('0, '0, 6'd1, 0);
        convert(W'(12345), 156'h12345, 6'd5, 10);
        convert('1, 156'h340282366920938463463374607431768211455, 6'd39, 0);

        // Reset in the middle of a conversion discards it.
        in_valid = 1'b1;
        bin_in   = W'(12345);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", 160'(out_valid), 160'(0));
        check("midrst_in_ready", 160'(in_ready), 160'(1));
        check("midrst_bcd", 160'(bcd_out), 160'(0));
        check("midrst_ndigits", 160'(ndigits), 160'(1));
        convert(W'(55), 156'h55, 6'd2, 0);

        convert(128'd354224848179261915075, 156'h354224848179261915075, 6'd21, 0);
        convert(W'(9), 156'h9, 6'd1, 0);
        convert(W'(1000000), 156'h1000000, 6'd7, 0);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 160'(q.size()), 160'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
